// File: rtl/key_color_adjuster_if.sv
// Key/colour bundle of key_color_adjuster: raw active-low keys in,
// per-channel intensities and change strobes out.
interface key_color_adjuster_if;
   logic [2:0] key;
   logic [3:0] ir;
   logic [3:0] ib;
   logic [3:0] ig;
   logic [2:0] key_pulse;

   modport master (output key, input ir, ib, ig, key_pulse);
   modport slave  (input key, output ir, ib, ig, key_pulse);
endinterface

// File: rtl/key_color_adjuster.sv
// Synchronises and debounces three active-low colour keys; each accepted press
// (and each auto-repeat tick while held) steps that channel's 4-bit intensity.
module key_color_adjuster #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_RATE     = 5000000,
   parameter int REPEAT_EN       = 1,
   parameter int CNT_W           = 25
) (
   input logic                 clk_in,
   input logic                 rst,
   key_color_adjuster_if.slave bus
);

   typedef enum logic [1:0] {
      RELEASED,
      DEB_PRESS,
      PRESSED,
      DEB_RELEASE
   } state_t;

   localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
   localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

   logic [2:0]       sync1;
   logic [2:0]       ks;
   state_t           state_q [3];
   state_t           state_d [3];
   logic [CNT_W-1:0] cnt_q   [3];
   logic [CNT_W-1:0] cnt_d   [3];
   logic [CNT_W-1:0] rpt_q   [3];
   logic [CNT_W-1:0] rpt_d   [3];
   logic             first_q [3];
   logic             first_d [3];
   logic             step    [3];
   logic [3:0]       col_q   [3];
   logic [2:0]       pulse_q;

   // Release/press events take priority over a repeat tick landing on the same edge.
   always_comb begin
      for (int unsigned i = 0; i < 3; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         rpt_d[i]   = rpt_q[i];
         first_d[i] = first_q[i];
         step[i]    = 1'b0;
         case (state_q[i])
            RELEASED: begin
               if (!ks[i]) begin
                  state_d[i] = DEB_PRESS;
                  cnt_d[i]   = '0;
               end
            end
            DEB_PRESS: begin
               if (ks[i]) begin
                  state_d[i] = RELEASED;
               end else if (cnt_q[i] == DEB_LAST) begin
                  state_d[i] = PRESSED;
                  step[i]    = 1'b1;
                  rpt_d[i]   = '0;
                  first_d[i] = 1'b1;
               end else begin
                  cnt_d[i] = cnt_q[i] + ONE;
               end
            end
            PRESSED: begin
               if (ks[i]) begin
                  state_d[i] = DEB_RELEASE;
                  cnt_d[i]   = '0;
               end else if (REPEAT_EN != 0) begin
                  if (rpt_q[i] == (first_q[i] ? DELAY_LAST : RATE_LAST)) begin
                     step[i]    = 1'b1;
                     rpt_d[i]   = '0;
                     first_d[i] = 1'b0;
                  end else begin
                     rpt_d[i] = rpt_q[i] + ONE;
                  end
               end
            end
            DEB_RELEASE: begin
               if (!ks[i]) begin
                  state_d[i] = PRESSED;
                  rpt_d[i]   = '0;
                  first_d[i] = 1'b1;
               end else if (cnt_q[i] == DEB_LAST) begin
                  state_d[i] = RELEASED;
               end else begin
                  cnt_d[i] = cnt_q[i] + ONE;
               end
            end
            default: state_d[i] = RELEASED;
         endcase
      end
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         sync1   <= '1;
         ks      <= '1;
         pulse_q <= '0;
         for (int unsigned i = 0; i < 3; i++) begin
            state_q[i] <= RELEASED;
            cnt_q[i]   <= '0;
            rpt_q[i]   <= '0;
            first_q[i] <= 1'b0;
            col_q[i]   <= '0;
         end
      end else begin
         sync1 <= bus.key;
         ks    <= sync1;
         for (int unsigned i = 0; i < 3; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
            rpt_q[i]   <= rpt_d[i];
            first_q[i] <= first_d[i];
            pulse_q[i] <= step[i];
            if (step[i]) col_q[i] <= col_q[i] + 4'd1;
         end
      end
   end

   assign bus.ir        = col_q[0];
   assign bus.ib        = col_q[1];
   assign bus.ig        = col_q[2];
   assign bus.key_pulse = pulse_q;

endmodule

// File: doc/key_color_adjuster.md
Name: key_color_adjuster

Overview:
Upstream conditioning stage for the RGB screen's colour inputs. It takes the three raw, active-low push-buttons (red, blue, green) and synchronises and debounces each one. Each accepted press advances that channel's 4-bit intensity register; holding a key auto-repeats. Outputs ir/ib/ig drive the sync/colour stage directly, replacing counters clocked on raw key edges with fully synchronous logic on clk_in.

Parameters:
DEBOUNCE_CYCLES, 1000000, cycles a key level must be stable before acceptance (20 ms at 50 MHz); must be >= 1
REPEAT_DELAY, 25000000, cycles after an accepted press before the first auto-repeat step; must be >= 1
REPEAT_RATE, 5000000, cycles between subsequent auto-repeat steps; must be >= 1
REPEAT_EN, 1, 1 = auto-repeat enabled, 0 = exactly one step per press
CNT_W, 25, width of the debounce and repeat counters; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE)

Ports:
clk_in  input  1  system clock (50 MHz board clock)
rst  input  1  asynchronous reset, active-high
key  input  3  raw push-buttons, active-low (0 = pressed); [0]=red, [1]=blue, [2]=green
ir  output  4  red intensity
ib  output  4  blue intensity
ig  output  4  green intensity
key_pulse  output  3  one-cycle strobe per channel, high in the cycle its colour value changes

Behaviour:
- Reset (async, active-high): ir=ib=ig=0, key_pulse=0, all synchroniser flops=1 (released), all FSMs RELEASED, all counters 0.
- Per key i: independent 2-flop synchroniser; ks_i is the second-stage output. No sharing of state between channels.
- Per-key FSM states: RELEASED, DEB_PRESS, PRESSED, DEB_RELEASE.
  - RELEASED: ks=0 -> DEB_PRESS, cnt<=0.
  - DEB_PRESS: ks=1 -> RELEASED, no step. ks=0 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED, step, rpt<=0, first<=1. Otherwise cnt++.
  - PRESSED: ks=1 -> DEB_RELEASE, cnt<=0. Otherwise, if REPEAT_EN, rpt++; when rpt == (first ? REPEAT_DELAY-1 : REPEAT_RATE-1): step, rpt<=0, first<=0.
  - DEB_RELEASE: ks=0 -> PRESSED, rpt<=0, first<=1, no step. ks=1 and cnt==DEBOUNCE_CYCLES-1 -> RELEASED. Otherwise cnt++.
- Step: colour register increments by 1 modulo 16 (15 -> 0 wrap, no saturation). key_pulse[i]=1 for exactly that cycle. Register and strobe update on the same clk_in edge as the FSM transition.
- Latency: count key[i] first sampled low at edge 1. Colour changes at edge DEBOUNCE_CYCLES+3 if the key stays low throughout.
- Glitch shorter than DEBOUNCE_CYCLES (after synchronisation) in RELEASED: no step.
- Simultaneous presses: channels fully independent; 0-3 steps may occur in one cycle.
- Reset mid-press: returns to reset values; after reset deasserts, a still-held key is debounced afresh (one new press).
- Outputs are plain registers; no combinational path from key to any output.

Test Plan:
Use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, REPEAT_EN=1 unless noted.
1. Reset, then hold key[0]=0 from edge 1 -> ir=1 and key_pulse=3'b001 at edge 7 only; ib=ig=0.
2. key[2] low for 2 cycles then high (bounce) -> ig stays 0, key_pulse[2] never asserts.
3. Hold key[1] low through edge 24 -> ib steps at edges 7, 17, 20, 23; final ib=4.
4. REPEAT_EN=0: 16 clean press/release cycles on key[0] -> ir counts 1..15 then 0; exactly 16 pulses.
5. Hold key[0] and key[2], release and re-press both together -> ir and ig step on identical edges, key_pulse=3'b101.
6. Hold key[0] past acceptance; release for 2 cycles, then press again (release debounce aborted) -> no extra step, repeat restarts 10 cycles later. Assert rst mid-hold -> ir=0 immediately; after rst drops with key held, ir=1 at edge DEBOUNCE_CYCLES+3.
